// File: rtl/xres_pkg.sv
// Shared types for the XRES reset sequencer: FSM state encodings, reset-cause codes
// and a small helper used to size the delay counter.
package xres_pkg;

    typedef enum logic [2:0] {
        ST_PAD_INIT  = 3'd0,
        ST_WAIT_REL  = 3'd1,
        ST_CORE_HOLD = 3'd2,
        ST_USER_HOLD = 3'd3,
        ST_RUN       = 3'd4,
        ST_SW_RST    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_PIN = 2'b01,
        CAUSE_SW  = 2'b10
    } rst_cause_e;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/xres_debounce.sv
// Two-flop synchroniser for the XRES pad output followed by a consecutive-sample
// debouncer; the debounced level only moves after DEBOUNCE_CYC differing samples.
module xres_debounce
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic xres_n_i,
    output logic deb_n_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_n_q, deb_n_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = xres_n_i;
        sync2_d = sync1_q;
        deb_n_d = deb_n_q;
        cnt_d   = '0;
        // Any sample matching the current level restarts the run count.
        if (en_i && (sync2_q != deb_n_q)) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                deb_n_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_n_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_n_q <= deb_n_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_n_o = deb_n_q;

endmodule

// File: rtl/xres_reset_sequencer.sv
// XRES pad controller: configures the pad, waits for a debounced release, then drops
// core reset before user reset; also runs software user resets and records the cause.
module xres_reset_sequencer
    import xres_pkg::*;
#(
    parameter int PAD_SETTLE   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int CORE_DLY     = 8,
    parameter int USER_DLY     = 8,
    parameter int SW_PULSE     = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       xres_n_i,
    input  logic       cfg_filt_en_i,
    input  logic       sw_rst_req_i,
    output logic       sw_rst_ack_o,
    output logic       pad_enable_h_o,
    output logic       pad_filt_in_h_o,
    output logic       pad_inp_sel_h_o,
    output logic       pad_dis_pullup_h_o,
    output logic       core_rst_o,
    output logic       user_rst_o,
    output logic [1:0] rst_cause_o,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = max_of4(PAD_SETTLE, CORE_DLY, USER_DLY, SW_PULSE);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e        state_q, state_d;
    rst_cause_e    cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          pad_en_q, pad_en_d;
    logic          pad_filt_q, pad_filt_d;
    logic          core_rst_q, core_rst_d;
    logic          user_rst_q, user_rst_d;
    logic          ack_q, ack_d;
    logic          deb_n;
    logic          pin_rst;

    // XRES is only sampled once the pad has been enabled and settled.
    xres_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .en_i     (state_q != ST_PAD_INIT),
        .xres_n_i (xres_n_i),
        .deb_n_o  (deb_n)
    );

    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    assign pin_rst = !deb_n && (state_q inside {ST_CORE_HOLD, ST_USER_HOLD, ST_RUN, ST_SW_RST});

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;
        pad_en_d   = pad_en_q;
        pad_filt_d = pad_filt_q;
        core_rst_d = core_rst_q;
        user_rst_d = user_rst_q;
        ack_d      = 1'b0;
        case (state_q)
            ST_PAD_INIT: begin
                pad_en_d   = 1'b1;
                pad_filt_d = cfg_filt_en_i;
                core_rst_d = 1'b1;
                user_rst_d = 1'b1;
                // Settle time counts from the cycle the enable is actually driven.
                if (pad_en_q && (cnt_q == CW'(PAD_SETTLE - 1))) begin
                    state_d = ST_WAIT_REL;
                    cnt_d   = '0;
                end else if (pad_en_q) begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_REL: begin
                core_rst_d = 1'b1;
                user_rst_d = 1'b1;
                cnt_d      = '0;
                if (deb_n) state_d = ST_CORE_HOLD;
            end
            ST_CORE_HOLD: begin
                if (cnt_q == CW'(CORE_DLY - 1)) begin
                    core_rst_d = 1'b0;
                    state_d    = ST_USER_HOLD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_USER_HOLD: begin
                if (cnt_q == CW'(USER_DLY - 1)) begin
                    user_rst_d = 1'b0;
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (sw_rst_req_i) begin
                    user_rst_d = 1'b1;
                    cause_d    = CAUSE_SW;
                    state_d    = ST_SW_RST;
                end
            end
            ST_SW_RST: begin
                user_rst_d = 1'b1;
                if (cnt_q == CW'(SW_PULSE - 1)) begin
                    ack_d   = 1'b1;
                    state_d = ST_USER_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_PAD_INIT;
                cnt_d   = '0;
            end
        endcase
        // A debounced pin reset overrides everything, including a pending software reset.
        if (pin_rst) begin
            core_rst_d = 1'b1;
            user_rst_d = 1'b1;
            cause_d    = CAUSE_PIN;
            cnt_d      = '0;
            ack_d      = 1'b0;
            state_d    = ST_WAIT_REL;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_PAD_INIT;
            cause_q    <= CAUSE_POR;
            cnt_q      <= '0;
            pad_en_q   <= 1'b0;
            pad_filt_q <= 1'b0;
            core_rst_q <= 1'b1;
            user_rst_q <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
            pad_en_q   <= pad_en_d;
            pad_filt_q <= pad_filt_d;
            core_rst_q <= core_rst_d;
            user_rst_q <= user_rst_d;
            ack_q      <= ack_d;
        end
    end

    assign sw_rst_ack_o       = ack_q;
    assign pad_enable_h_o     = pad_en_q;
    assign pad_filt_in_h_o    = pad_filt_q;
    assign pad_inp_sel_h_o    = 1'b0;
    assign pad_dis_pullup_h_o = 1'b0;
    assign core_rst_o         = core_rst_q;
    assign user_rst_o         = user_rst_q;
    assign rst_cause_o        = cause_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Bench for xres_reset_sequencer: power-up sequencing, pin glitch/reset, software reset,
// pin-vs-software race and mid-sequence wb_rst_i, with continuous invariant checks.
module tb_xres_reset_sequencer;

    localparam int PAD_SETTLE   = 4;
    localparam int DEBOUNCE_CYC = 16;
    localparam int CORE_DLY     = 8;
    localparam int USER_DLY     = 8;
    localparam int SW_PULSE     = 4;

    localparam int SIG_CORE = 0;
    localparam int SIG_USER = 1;
    localparam int SIG_ACK  = 2;
    localparam int SIG_PAD  = 3;

    // Latencies in clock edges, counted from the edge after the stimulus change.
    localparam int LAT_POR_CORE = PAD_SETTLE + 2 + DEBOUNCE_CYC + CORE_DLY;
    localparam int LAT_PIN_ASSERT = 2 + DEBOUNCE_CYC + 1;
    localparam int LAT_PIN_CORE = 2 + DEBOUNCE_CYC + 1 + CORE_DLY;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       xres_n = 1'b1;
    logic       cfg_filt = 1'b0;
    logic       sw_req = 1'b0;
    logic       ack, pad_en, pad_filt, pad_inp_sel, pad_dis_pu, core_rst, user_rst;
    logic [1:0] cause;
    logic [2:0] state;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          ack_seen = 0;
    logic        ack_prev = 1'b0;
    logic [15:0] exp_q[$];

    xres_reset_sequencer #(
        .PAD_SETTLE(PAD_SETTLE), .DEBOUNCE_CYC(DEBOUNCE_CYC), .CORE_DLY(CORE_DLY),
        .USER_DLY(USER_DLY), .SW_PULSE(SW_PULSE)
    ) dut (
        .wb_clk_i           (clk),
        .wb_rst_i           (rst),
        .xres_n_i           (xres_n),
        .cfg_filt_en_i      (cfg_filt),
        .sw_rst_req_i       (sw_req),
        .sw_rst_ack_o       (ack),
        .pad_enable_h_o     (pad_en),
        .pad_filt_in_h_o    (pad_filt),
        .pad_inp_sel_h_o    (pad_inp_sel),
        .pad_dis_pullup_h_o (pad_dis_pu),
        .core_rst_o         (core_rst),
        .user_rst_o         (user_rst),
        .rst_cause_o        (cause),
        .state_o            (state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            SIG_CORE: return core_rst;
            SIG_USER: return user_rst;
            SIG_ACK:  return ack;
            default:  return pad_en;
        endcase
    endfunction

    task automatic wait_lvl(input int which, input logic lvl, input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel(which) === lvl) begin
                when = cyc;
                break;
            end
        end
    endtask

    // Scoreboard pop: compare an observed latency with the oldest expected one.
    task automatic expect_lat(input string tag, input int when, input int ref_cyc);
        logic [15:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hdead;
        if (when < 0) chk(tag, 16'hffff, e);
        else          chk(tag, 16'(when - ref_cyc), e);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_pad_en"},   16'(pad_en), 16'd0);
        chk({pfx, "_pad_filt"}, 16'(pad_filt), 16'd0);
        chk({pfx, "_inp_sel"},  16'(pad_inp_sel), 16'd0);
        chk({pfx, "_dis_pu"},   16'(pad_dis_pu), 16'd0);
        chk({pfx, "_core"},     16'(core_rst), 16'd1);
        chk({pfx, "_user"},     16'(user_rst), 16'd1);
        chk({pfx, "_ack"},      16'(ack), 16'd0);
        chk({pfx, "_cause"},    16'(cause), 16'd0);
        chk({pfx, "_state"},    16'(state), 16'd0);
    endtask

    // Continuous invariants: core released no later than user; ack one cycle wide.
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_core_first", 16'(!(!user_rst && core_rst)), 16'd1);
            chk("ack_width", 16'(ack && ack_prev), 16'd0);
            if (ack) ack_seen <= ack_seen + 1;
        end
        ack_prev <= ack;
    end

    // ---------------- stimulus ----------------
    initial begin
        int   w, t0, a0;
        logic hit;

        // 1: power-up with XRES released from time zero
        repeat (3) @(negedge clk);
        chk_reset_vals("por_reset");
        exp_q.push_back(16'd1);
        exp_q.push_back(16'(LAT_POR_CORE));
        exp_q.push_back(16'(LAT_POR_CORE + USER_DLY));
        rst = 1'b0;
        t0 = cyc;
        wait_lvl(SIG_PAD, 1'b1, 10, w);   expect_lat("por_pad_en", w, t0);
        wait_lvl(SIG_CORE, 1'b0, 100, w); expect_lat("por_core_fall", w, t0);
        wait_lvl(SIG_USER, 1'b0, 100, w); expect_lat("por_user_fall", w, t0);
        chk("por_cause", 16'(cause), 16'd0);
        chk("por_state_run", 16'(state), 16'd4);

        // 2a: short glitch must not disturb RUN
        repeat (3) @(negedge clk);
        hit = 1'b0;
        xres_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hit = hit | core_rst | user_rst;
        end
        xres_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            hit = hit | core_rst | user_rst;
        end
        chk("glitch_no_rst", 16'(hit), 16'd0);
        chk("glitch_state_run", 16'(state), 16'd4);

        // 2b: long low is a pin reset, then staged release
        exp_q.push_back(16'(LAT_PIN_ASSERT));
        xres_n = 1'b0;
        t0 = cyc;
        wait_lvl(SIG_CORE, 1'b1, 40, w); expect_lat("pin_core_assert", w, t0);
        chk("pin_user_assert", 16'(user_rst), 16'd1);
        chk("pin_cause", 16'(cause), 16'd1);
        chk("pin_state_wait", 16'(state), 16'd1);
        while (cyc - t0 < 20) @(negedge clk);
        exp_q.push_back(16'(LAT_PIN_CORE));
        exp_q.push_back(16'(LAT_PIN_CORE + USER_DLY));
        xres_n = 1'b1;
        t0 = cyc;
        wait_lvl(SIG_CORE, 1'b0, 60, w); expect_lat("pin_core_fall", w, t0);
        wait_lvl(SIG_USER, 1'b0, 60, w); expect_lat("pin_user_fall", w, t0);

        // 3: software reset handshake
        repeat (3) @(negedge clk);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'(1 + SW_PULSE));
        exp_q.push_back(16'(1 + SW_PULSE + USER_DLY));
        a0 = ack_seen;
        sw_req = 1'b1;
        t0 = cyc;
        wait_lvl(SIG_USER, 1'b1, 10, w); expect_lat("sw_user_rise", w, t0);
        chk("sw_core_low_a", 16'(core_rst), 16'd0);
        wait_lvl(SIG_ACK, 1'b1, 20, w);  expect_lat("sw_ack", w, t0);
        sw_req = 1'b0;
        chk("sw_core_low_b", 16'(core_rst), 16'd0);
        chk("sw_user_high", 16'(user_rst), 16'd1);
        wait_lvl(SIG_USER, 1'b0, 30, w); expect_lat("sw_user_fall", w, t0);
        chk("sw_cause", 16'(cause), 16'd2);
        @(negedge clk);
        chk("sw_ack_count", 16'(ack_seen - a0), 16'd1);
        chk("sw_state_run", 16'(state), 16'd4);

        // 4: software request lands on the cycle the debounced level falls
        repeat (3) @(negedge clk);
        exp_q.push_back(16'(LAT_PIN_ASSERT));
        a0 = ack_seen;
        xres_n = 1'b0;
        t0 = cyc;
        while (cyc - t0 < LAT_PIN_ASSERT - 1) @(negedge clk);
        sw_req = 1'b1;
        wait_lvl(SIG_CORE, 1'b1, 5, w); expect_lat("race_core_assert", w, t0);
        chk("race_user", 16'(user_rst), 16'd1);
        chk("race_cause", 16'(cause), 16'd1);
        repeat (4) @(negedge clk);
        chk("race_state_wait", 16'(state), 16'd1);
        chk("race_no_ack", 16'(ack_seen - a0), 16'd0);
        sw_req = 1'b0;
        exp_q.push_back(16'(LAT_PIN_CORE));
        exp_q.push_back(16'(LAT_PIN_CORE + USER_DLY));
        xres_n = 1'b1;
        t0 = cyc;
        wait_lvl(SIG_CORE, 1'b0, 60, w); expect_lat("race_core_fall", w, t0);
        wait_lvl(SIG_USER, 1'b0, 60, w); expect_lat("race_user_fall", w, t0);

        // 5: wb_rst_i during USER_HOLD, filter enable re-latched
        repeat (2 + $urandom_range(0, 3)) @(negedge clk);
        sw_req = 1'b1;
        wait_lvl(SIG_ACK, 1'b1, 20, w);
        sw_req = 1'b0;
        chk("mid_state_user_hold", 16'(state), 16'd3);
        rst = 1'b1;
        cfg_filt = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        exp_q.push_back(16'(LAT_POR_CORE));
        exp_q.push_back(16'(LAT_POR_CORE + USER_DLY));
        rst = 1'b0;
        t0 = cyc;
        @(negedge clk);
        chk("mid_pad_en", 16'(pad_en), 16'd1);
        chk("mid_pad_filt", 16'(pad_filt), 16'd1);
        wait_lvl(SIG_CORE, 1'b0, 100, w); expect_lat("mid_core_fall", w, t0);
        wait_lvl(SIG_USER, 1'b0, 100, w); expect_lat("mid_user_fall", w, t0);
        chk("mid_cause", 16'(cause), 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
